// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: turns a signed phase angle into cosine and
// sine with one micro-rotation per clock. The arctangent table sits outside;
// this block drives its address with the iteration index and consumes the
// constant combinationally in the same cycle.
module cordic_rotator #(
   parameter int               N_ITER = 16,
   parameter int               WIDTH  = 20,
   parameter logic [WIDTH-1:0] X_INIT = 20'h04DBA
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] angle_in,
   output logic [3:0]       rom_addr,
   input  logic [WIDTH-1:0] rom_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] cos_out,
   output logic [WIDTH-1:0] sin_out,
   output logic             range_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // +/- pi/2 in the 2^15-per-radian angle scale.
   localparam logic signed [WIDTH-1:0] ANG_LIM  = WIDTH'(20'sh0C910);
   localparam logic [3:0]              LAST_IDX = 4'(N_ITER - 1);

   state_t                  state_q;
   logic signed [WIDTH-1:0] x_q;
   logic signed [WIDTH-1:0] y_q;
   logic signed [WIDTH-1:0] z_q;
   logic [3:0]              i_q;
   logic                    range_q;
   logic                    busy_q;
   logic                    done_q;
   logic [WIDTH-1:0]        cos_q;
   logic [WIDTH-1:0]        sin_q;
   logic                    range_err_q;

   logic signed [WIDTH-1:0] x_d;
   logic signed [WIDTH-1:0] y_d;
   logic signed [WIDTH-1:0] z_d;
   logic signed [WIDTH-1:0] x_sh_s;
   logic signed [WIDTH-1:0] y_sh_s;
   logic                    range_d;
   logic                    last_s;
   logic                    accept_s;

   // One micro-rotation from the current vector, plus capture-side decisions.
   always_comb begin
      x_sh_s   = x_q >>> i_q;
      y_sh_s   = y_q >>> i_q;
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      if (z_q[WIDTH-1]) begin
         // Residual angle negative: rotate clockwise.
         x_d = x_q + y_sh_s;
         y_d = y_q - x_sh_s;
         z_d = z_q + $signed(rom_data);
      end else begin
         x_d = x_q - y_sh_s;
         y_d = y_q + x_sh_s;
         z_d = z_q - $signed(rom_data);
      end
      range_d  = ($signed(angle_in) > ANG_LIM) || ($signed(angle_in) < -ANG_LIM);
      last_s   = (i_q == LAST_IDX);
      // A new request is only taken when not iterating; DONE counts as free.
      accept_s = start && ((state_q == IDLE) || (state_q == DONE));
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         i_q         <= 4'd0;
         range_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cos_q       <= '0;
         sin_q       <= '0;
         range_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (accept_s) begin
                  x_q     <= X_INIT;
                  y_q     <= '0;
                  z_q     <= angle_in;
                  i_q     <= 4'd0;
                  range_q <= range_d;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               x_q <= x_d;
               y_q <= y_d;
               z_q <= z_d;
               if (last_s) begin
                  cos_q       <= x_d;
                  sin_q       <= y_d;
                  range_err_q <= range_q;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  i_q         <= 4'd0;
                  state_q     <= DONE;
               end else begin
                  i_q <= i_q + 4'd1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               i_q     <= 4'd0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // The index register is zero outside RUN, so it doubles as the table address.
   assign rom_addr  = i_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cos_out   = cos_q;
   assign sin_out   = sin_q;
   assign range_err = range_err_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// Bench for cordic_rotator: an arctangent table, a transaction-level model
// that predicts every output every cycle, and directed plus random stimulus.
module tb_cordic_rotator;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [19:0] angle_in = 20'd0;
   logic [3:0]  rom_addr;
   logic [19:0] rom_data;
   logic        busy;
   logic        done;
   logic [19:0] cos_out;
   logic [19:0] sin_out;
   logic        range_err;

   int compared = 0;
   int mismatched = 0;

   cordic_rotator dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .angle_in  (angle_in),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .busy      (busy),
      .done      (done),
      .cos_out   (cos_out),
      .sin_out   (sin_out),
      .range_err (range_err)
   );

   always #5 clk = ~clk;

   // round(atan(2^-i) * 2^15)
   function automatic logic [19:0] atan_tab(input logic [3:0] a);
      case (a)
         4'd0:  atan_tab = 20'd25736;
         4'd1:  atan_tab = 20'd15193;
         4'd2:  atan_tab = 20'd8027;
         4'd3:  atan_tab = 20'd4075;
         4'd4:  atan_tab = 20'd2045;
         4'd5:  atan_tab = 20'd1024;
         4'd6:  atan_tab = 20'd512;
         4'd7:  atan_tab = 20'd256;
         4'd8:  atan_tab = 20'd128;
         4'd9:  atan_tab = 20'd64;
         4'd10: atan_tab = 20'd32;
         4'd11: atan_tab = 20'd16;
         4'd12: atan_tab = 20'd8;
         4'd13: atan_tab = 20'd4;
         4'd14: atan_tab = 20'd2;
         4'd15: atan_tab = 20'd1;
         default: atan_tab = 20'd0;
      endcase
   endfunction

   assign rom_data = atan_tab(rom_addr);

   // Whole-conversion reference: the rotation recurrence on 20-bit wrapping values.
   function automatic void model_cordic(input logic [19:0] a, output int c, output int s,
                                        output bit e);
      logic signed [19:0] x, y, z, xn, yn;
      x = 20'sh04DBA;
      y = 20'sd0;
      z = $signed(a);
      for (int i = 0; i < N; i++) begin
         if (z >= 20'sd0) begin
            xn = x - (y >>> i);
            yn = y + (x >>> i);
            z  = z - $signed(atan_tab(4'(i)));
         end else begin
            xn = x + (y >>> i);
            yn = y - (x >>> i);
            z  = z + $signed(atan_tab(4'(i)));
         end
         x = xn;
         y = yn;
      end
      c = int'(x);
      s = int'(y);
      e = ($signed(a) > 20'sh0C910) || ($signed(a) < -20'sh0C910);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_tol(input string name, input int act, input int exp, input int tol);
      compared++;
      if (act > exp + tol || act < exp - tol) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   // ---------------- transaction-level model ----------------
   int edge_cnt  = 0;
   bit active    = 1'b0;
   int acc_edge  = 0;
   int next_free = 0;
   int pend_c = 0, pend_s = 0, cur_c = 0, cur_s = 0;
   bit pend_e = 1'b0, cur_e = 1'b0;

   // Tracks accepted requests by edge number and publishes results N edges later.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         active    = 1'b0;
         next_free = 0;
         cur_c     = 0;
         cur_s     = 0;
         cur_e     = 1'b0;
      end else begin
         edge_cnt++;
         if (active && edge_cnt == acc_edge + N) begin
            cur_c = pend_c;
            cur_s = pend_s;
            cur_e = pend_e;
         end
         if (start && edge_cnt >= next_free) begin
            active    = 1'b1;
            acc_edge  = edge_cnt;
            model_cordic(angle_in, pend_c, pend_s, pend_e);
            next_free = edge_cnt + N + 1;
         end
      end
   end

   // Per-cycle comparison of every output against the model, mid-cycle.
   always @(negedge clk) begin
      bit bexp, dexp;
      int rexp;
      bexp = active && edge_cnt >= acc_edge && edge_cnt < acc_edge + N;
      dexp = active && edge_cnt == acc_edge + N;
      rexp = bexp ? edge_cnt - acc_edge : 0;
      chk("busy", int'(busy), int'(bexp));
      chk("done", int'(done), int'(dexp));
      chk("rom_addr", int'(rom_addr), rexp);
      chk("cos_out", int'($signed(cos_out)), cur_c);
      chk("sin_out", int'($signed(sin_out)), cur_s);
      chk("range_err", int'(range_err), int'(cur_e));
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_rom_addr"}, int'(rom_addr), 0);
      chk({tag, "_cos"}, int'(cos_out), 0);
      chk({tag, "_sin"}, int'(sin_out), 0);
      chk({tag, "_range_err"}, int'(range_err), 0);
   endtask

   // mode 0: model only; 1: literal cos/sin/err; 2: literal err only
   task automatic run_conv(input logic [19:0] a, input int mode, input int ec, input int es,
                           input int ee);
      int  cnt;
      bit  seen;
      @(negedge clk);
      start    = 1'b1;
      angle_in = a;
      @(negedge clk);
      start = 1'b0;
      cnt   = 1;
      seen  = 1'b0;
      while (cnt < 40 && !seen) begin
         if (done) seen = 1'b1;
         else begin
            @(negedge clk);
            cnt++;
         end
      end
      chk("done_latency", seen ? cnt : -1, N + 1);
      if (mode == 1) begin
         chk_tol("lit_cos", int'($signed(cos_out)), ec, 8);
         chk_tol("lit_sin", int'($signed(sin_out)), es, 8);
      end
      if (mode != 0) chk("lit_range_err", int'(range_err), ee);
   endtask

   initial begin
      int mc, ms;
      bit me;
      int nd, last_t, cnt;
      bit seen;

      // async reset between edges: outputs clear at once
      #2 reset = 1'b1;
      #1 chk_all_zero("reset_async");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // pin the model with hand values
      model_cordic(20'h00000, mc, ms, me);
      chk_tol("model_cos0", mc, 32768, 8);
      chk_tol("model_sin0", ms, 0, 8);
      model_cordic(20'h06487, mc, ms, me);
      chk_tol("model_cos45", mc, 23170, 8);
      chk_tol("model_sin45", ms, 23170, 8);

      run_conv(20'h00000, 1, 32768, 0, 0);
      run_conv(20'h06487, 1, 23170, 23170, 0);
      run_conv(20'hF9B79, 1, 23170, -23170, 0);
      run_conv(20'h0C90F, 1, 0, 32768, 0);
      run_conv(20'h10000, 2, 0, 0, 1);
      run_conv(20'h0C910, 2, 0, 0, 0);
      run_conv(20'h0C911, 2, 0, 0, 1);
      run_conv(20'hF36F0, 2, 0, 0, 0);
      run_conv(20'hF36EF, 2, 0, 0, 1);

      // start held high with a fresh angle every cycle
      @(negedge clk);
      start  = 1'b1;
      nd     = 0;
      last_t = 0;
      for (int n = 1; n <= 60; n++) begin
         angle_in = 20'($urandom);
         @(negedge clk);
         if (done) begin
            if (nd > 0) chk("held_done_spacing", n - last_t, N + 1);
            nd++;
            last_t = n;
         end
      end
      start = 1'b0;
      chk("held_done_count", nd, 3);
      repeat (25) @(negedge clk);

      // reset in the middle of a conversion
      @(negedge clk);
      start    = 1'b1;
      angle_in = 20'h03000;
      @(negedge clk);
      start = 1'b0;
      cnt   = 0;
      while (rom_addr != 4'd7 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk("reach_iter7", int'(rom_addr), 7);
      #2 reset = 1'b1;
      #1 chk_all_zero("reset_midrun");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("no_done_after_abort", int'(seen), 0);
      chk("cos_after_abort", int'(cos_out), 0);
      run_conv(20'h06487, 1, 23170, 23170, 0);

      // random requests with start pulses of random length
      for (int t = 0; t < 80; t++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         start = 1'b1;
         for (int k = 0, len = $urandom_range(1, 20); k < len; k++) begin
            if ($urandom_range(0, 1) == 0)
               angle_in = 20'($signed($urandom_range(0, 102944)) - 51472);
            else
               angle_in = 20'($urandom);
            @(negedge clk);
         end
         start = 1'b0;
      end
      repeat (25) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cordic_rotator.md
# cordic_rotator

Iterative rotation-mode CORDIC engine that converts a signed phase angle into cosine and sine. It sits directly downstream of the arctangent constant table in the DDS path. The engine drives the table's 4-bit address with its iteration index and consumes the 20-bit constant on the same cycle. It performs one micro-rotation per clock under a start/busy/done handshake and feeds the DDS output stage.

## Interface
- N_ITER, 16: micro-rotations per conversion. Legal range 1..16, bounded by the table depth.
- WIDTH, 20: datapath width of x, y, z, angle and results. Must match the table data width.
- X_INIT, 20'h04DBA: initial x. This is the CORDIC gain compensation K≈0.607253 scaled by 2^15.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only while busy=0.
- angle_in  input  20  signed two's-complement angle, scale 2^15 per radian (pi/4 = 20'h06487).
- rom_addr  output  4  arctangent table address (iteration index).
- rom_data  input  20  arctangent constant returned combinationally for rom_addr.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when results update.
- cos_out  output  20  signed cosine, scale 2^15 (1.0 ≈ 20'h08000).
- sin_out  output  20  signed sine, same scale.
- range_err  output  1  set with done when the captured angle was outside ±pi/2.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1, go to RUN.
  - RUN: stay until the iteration counter reaches N_ITER-1, then go to DONE.
  - DONE: lasts exactly one cycle. On start=1, go to RUN; otherwise go to IDLE.
- busy=1 only in RUN. done=1 only in DONE. start is ignored while busy=1; there is no queueing.
- Capture on start acceptance:
  - x←X_INIT, y←0, z←angle_in, i←0.
  - range_err_next ← (angle_in > 20'sh0C910) or (angle_in < -20'sh0C910).
- RUN, each cycle with index i:
  - rom_addr=i.
  - d=+1 if z≥0 (sign bit clear), else d=-1.
  - x←x−d·(y>>>i), y←y+d·(x>>>i), z←z−d·rom_data.
  - All right shifts are arithmetic and truncate (no rounding). All three updates use pre-update values.
- Arithmetic is WIDTH-bit two's complement with wrap-around. No saturation is needed inside ±pi/2, where |x|,|y| < 2^16.
- On the last RUN cycle, the final x and y load into cos_out and sin_out, and range_err loads. These outputs hold until the next completion.
- Out-of-range angles are still processed. The results are deterministic but not meaningful, and range_err flags them.
- rom_addr=0 outside RUN.

## Timing
- All outputs reset to 0: busy, done, cos_out, sin_out, range_err, rom_addr. The FSM resets to IDLE and the counter to 0.
- Reset asserted mid-conversion aborts immediately. There is no done pulse for the aborted conversion, and results return to 0.
- Latency: start sampled at edge T → busy=1 from T through T+N_ITER. done=1 and new results are visible in the cycle after edge T+N_ITER (busy=0 there).
- Back-to-back: start held high gives one conversion per N_ITER+1 cycles (17 at default). The new capture occurs at the DONE edge.
- start arriving on the same edge as the final iteration is ignored.
- rom_data must settle within the same cycle rom_addr is driven. The table is combinational and adds no cycle.

## Test plan
- Reset and idle: assert reset asynchronously between edges → all outputs read 0 immediately. Release reset with start=0 for 20 cycles → busy=0, done=0, rom_addr=0 throughout.
- angle_in=0, one start → done exactly 17 cycles after the start edge, cos_out=32768±8, sin_out=0±8, range_err=0. rom_addr steps 0..15 during busy.
- angle_in=20'h06487 → cos_out and sin_out both 23170±8 (0x5A82). angle_in=-20'h06487 (20'hF9B79) → cos_out=23170±8, sin_out=-23170±8.
- angle_in=20'h0C90F → cos_out=0±8, sin_out=32768±8, range_err=0. angle_in=20'h10000 → range_err=1 with done.
- Start held high for 60 cycles with angle_in changing each cycle → done pulses at 17-cycle spacing. Each result matches the angle present at its capture edge, and mid-run start pulses have no effect.
- Reset pulsed at iteration 7 of a conversion → no done pulse, outputs stay 0. A fresh start after release produces a correct result at the normal latency.
